// File: rtl/serial_add_sub.sv
// Purpose: bit-serial two's-complement adder/subtractor, BITS_PER_CYCLE full-adder slices per cycle.
// Latency: WIDTH/BITS_PER_CYCLE+1 cycles from the accept cycle to out_valid_out; one operation in flight.
// Backpressure: result held in DONE until out_ready_in; in_ready_out only in IDLE, so min issue interval is WIDTH/BITS_PER_CYCLE+2.
module serial_add_sub #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1   // WIDTH must be an integer multiple of this
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    input  logic             sub_in,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             overflow_out
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [WIDTH-1:0]          a_q;
    logic [WIDTH-1:0]          b_q;      // already inverted for subtraction
    logic [WIDTH-1:0]          sum_q;
    logic                      carry_q;  // chain carry between cycles
    logic [CW-1:0]             cnt_q;
    logic                      ready_q;
    logic                      valid_q;
    logic                      co_q;
    logic                      ov_q;

    logic [BITS_PER_CYCLE-1:0] slice_sum;
    logic [BITS_PER_CYCLE:0]   chain;
    logic [WIDTH-1:0]          a_nxt;
    logic [WIDTH-1:0]          b_nxt;
    logic [WIDTH-1:0]          sum_nxt;

    // Ripple chain over the low BITS_PER_CYCLE operand bits, plus next shift-register contents.
    always_comb begin
        slice_sum = '0;
        chain     = '0;
        chain[0]  = carry_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            slice_sum[i]  = a_q[i] ^ b_q[i] ^ chain[i];
            chain[i + 1]  = (a_q[i] & b_q[i]) | (chain[i] & (a_q[i] ^ b_q[i]));
        end
        a_nxt   = a_q >> BITS_PER_CYCLE;
        b_nxt   = b_q >> BITS_PER_CYCLE;
        sum_nxt = sum_q >> BITS_PER_CYCLE;
        sum_nxt[WIDTH-1 -: BITS_PER_CYCLE] = slice_sum;
    end

    // Control FSM and datapath registers; every output comes straight from a flop.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // First edge after reset only raises ready; accepts need ready already high.
                    ready_q <= 1'b1;
                    if (ready_q && in_valid_in) begin
                        a_q     <= a_in;
                        b_q     <= sub_in ? ~b_in : b_in;
                        carry_q <= sub_in ? 1'b1 : carry_in;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_nxt;
                    b_q     <= b_nxt;
                    sum_q   <= sum_nxt;
                    carry_q <= chain[BITS_PER_CYCLE];
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) begin
                        // Last group holds the MSB: capture its carry-out and signed overflow.
                        co_q    <= chain[BITS_PER_CYCLE];
                        ov_q    <= chain[BITS_PER_CYCLE-1] ^ chain[BITS_PER_CYCLE];
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_in) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_out  = ready_q;
    assign out_valid_out = valid_q;
    assign sum_out       = sum_q;
    assign carry_out     = co_q;
    assign overflow_out  = ov_q;

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter BITS_PER_CYCLE, default 1, giving the number of full-adder slices evaluated per cycle; WIDTH SHALL be an integer multiple of BITS_PER_CYCLE.
REQ-003 clk_in  input  1  clock; all state changes on the rising edge.
REQ-004 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 in_valid_in  input  1  operands and mode are valid.
REQ-006 in_ready_out  output  1  block accepts operands.
REQ-007 a_in  input  WIDTH  operand A.
REQ-008 b_in  input  WIDTH  operand B.
REQ-009 carry_in  input  1  carry-in, ignored when sub_in=1.
REQ-010 sub_in  input  1  0 selects A+B+carry_in; 1 selects A-B.
REQ-011 out_valid_out  output  1  result is valid.
REQ-012 out_ready_in  input  1  consumer accepts the result.
REQ-013 sum_out  output  WIDTH  result.
REQ-014 carry_out  output  1  carry out of the MSB; for subtraction, 1 means no borrow.
REQ-015 overflow_out  output  1  two's-complement overflow.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-017 in_ready_out SHALL be 1 only in IDLE, and out_valid_out SHALL be 1 only in DONE.
REQ-018 In IDLE, in_valid_in=1 SHALL trigger an accept: latch a_in; latch b_in, inverted when sub_in=1; latch the carry as carry_in, or as 1 when sub_in=1; clear the slice counter; go to RUN.
REQ-019 In RUN, each cycle SHALL process BITS_PER_CYCLE bits LSB-first through a chain of full-adder slices (sum = a^b^c, carry = ab|c(a^b)), shifting the result into the sum register and registering the chain carry for the next cycle.
REQ-020 RUN SHALL last exactly WIDTH/BITS_PER_CYCLE cycles, then the FSM SHALL go to DONE.
REQ-021 Accept-to-out_valid_out latency SHALL be WIDTH/BITS_PER_CYCLE+1 cycles; WIDTH=8, BITS_PER_CYCLE=1 gives 9.
REQ-022 On entry to DONE, carry_out SHALL equal the carry out of bit WIDTH-1, and overflow_out SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-023 In DONE, sum_out, carry_out and overflow_out SHALL hold stable until out_ready_in=1, then the FSM SHALL return to IDLE on the next edge.
REQ-024 Because in_ready_out=0 in DONE, in_valid_in=1 together with out_ready_in=1 in DONE SHALL NOT be accepted; the new operands are accepted in IDLE one cycle later, for a minimum issue interval of WIDTH/BITS_PER_CYCLE+2 cycles.
REQ-025 Changes on a_in, b_in, carry_in and sub_in during RUN or DONE SHALL NOT affect the result.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH, with the carry reported only through carry_out.
REQ-027 sum_out, carry_out and overflow_out outside DONE are don't-care to consumers, but SHALL be driven from registers, never from combinational paths off the inputs.

Reset
REQ-028 rst_n_in=0 SHALL immediately, without waiting for a clock edge, force: state IDLE, in_ready_out=0 while reset is asserted, out_valid_out=0, sum_out=0, carry_out=0, overflow_out=0, and all internal registers to 0.
REQ-029 A reset asserted in RUN or DONE SHALL abort the operation without a partial result ever becoming valid.
REQ-030 After rst_n_in deasserts, in_ready_out SHALL be 1 from the first rising edge.

Verification
REQ-031 WIDTH=8, BITS_PER_CYCLE=1: A=0x0F, B=0x01, cin=0, add -> 9 cycles after accept: sum=0x10, carry=0, ovf=0.
REQ-032 A=0xFF, B=0x01, add -> sum=0x00, carry=1, ovf=0; then A=0x7F, B=0x01 -> sum=0x80, carry=0, ovf=1.
REQ-033 A=0x05, B=0x07, sub -> sum=0xFE, carry=0 (borrow), ovf=0; then A=0x80, B=0x01, sub -> sum=0x7F, carry=1, ovf=1.
REQ-034 out_ready_in held 0 for 5 cycles in DONE, with a_in and b_in toggling -> outputs stable and in_ready_out=0 throughout; in_valid_in=1 in the out_ready_in cycle is accepted only one cycle later.
REQ-035 rst_n_in pulsed low during the 4th RUN cycle -> all outputs 0 immediately, no out_valid_out pulse, and a fresh 0x12+0x34 afterwards gives 0x46.
REQ-036 WIDTH=16, BITS_PER_CYCLE=4, A=0xFFFF, B=0x0001, cin=1 -> latency 5, sum=0x0001, carry=1; randomized add/sub results SHALL match a reference model.
